// File: rtl/face_pkg.sv
// Shared widths, tracker state type, box record and RGB565 colours for the face box overlay.
package face_pkg;

    localparam int unsigned COORD_W = 12;
    localparam int unsigned RGB_W   = 16;
    localparam int unsigned MISS_W  = 4;

    typedef enum logic [1:0] {
        StNoBox = 2'd0,
        StTrack = 2'd1,
        StCoast = 2'd2
    } track_state_e;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        coord_t x0;
        coord_t x1;
        coord_t y0;
        coord_t y1;
    } box_t;

    localparam logic [RGB_W-1:0] Rgb565Red   = 16'hF800;
    localparam logic [RGB_W-1:0] Rgb565Green = 16'h07E0;
    localparam logic [RGB_W-1:0] Rgb565Blue  = 16'h001F;

    // Floor of the mean of two coordinates, summed one bit wider so it never wraps.
    function automatic coord_t coord_avg(input coord_t a, input coord_t b);
        logic [COORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COORD_W:1];
    endfunction

endpackage

// File: rtl/face_box_overlay_if.sv
// RGB565 video stream bundle: frame sync, line valid, pixel strobe and pixel data.
interface face_box_overlay_if;
    import face_pkg::*;

    logic             vsync;
    logic             href;
    logic             clken;
    logic [RGB_W-1:0] rgb;

    modport master (output vsync, href, clken, rgb);
    modport slave  (input  vsync, href, clken, rgb);

endinterface

// File: rtl/face_box_tracker.sv
// Per-frame box latch: vsync edge detect, validity check, track/coast FSM.
// Optional BOX_SMOOTH_EN averages each update with the previous box.
module face_box_tracker
    import face_pkg::*;
#(
    parameter int unsigned H_DISP      = 1024,
    parameter int unsigned V_DISP      = 720,
    parameter int unsigned MIN_SIZE    = 8,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   vsync_i,
    input  coord_t x_min_i,
    input  coord_t x_max_i,
    input  coord_t y_min_i,
    input  coord_t y_max_i,
    output logic   vsync_rise_o,
    output box_t   box_o,
    output logic   box_valid_o
);

    localparam logic [COORD_W:0]  HDisp   = (COORD_W+1)'(H_DISP);
    localparam logic [COORD_W:0]  VDisp   = (COORD_W+1)'(V_DISP);
    localparam logic [COORD_W:0]  XLast   = (COORD_W+1)'(H_DISP - 1);
    localparam logic [COORD_W:0]  YLast   = (COORD_W+1)'(V_DISP - 1);
    localparam logic [COORD_W:0]  MinSz   = (COORD_W+1)'(MIN_SIZE);
    localparam logic [MISS_W-1:0] HoldMax = MISS_W'(HOLD_FRAMES);

    logic              vsync_q;
    track_state_e      state_q;
    logic [MISS_W-1:0] miss_q;
    box_t              box_q;
    logic              box_valid_q;

    logic              vsync_rise;
    logic              box_ok;
    logic [COORD_W:0]  x_min_w, x_max_w, y_min_w, y_max_w;
    box_t              box_new;
    box_t              box_upd;

    assign vsync_rise = vsync_i & ~vsync_q;

    always_comb begin
        x_min_w = {1'b0, x_min_i};
        x_max_w = {1'b0, x_max_i};
        y_min_w = {1'b0, y_min_i};
        y_max_w = {1'b0, y_max_i};
        box_ok  = (x_max_w >= x_min_w + MinSz) && (y_max_w >= y_min_w + MinSz) &&
                  (x_min_w < HDisp) && (y_min_w < VDisp);
        box_new.x0 = x_min_i;
        box_new.x1 = (x_max_w > XLast) ? XLast[COORD_W-1:0] : x_max_i;
        box_new.y0 = y_min_i;
        box_new.y1 = (y_max_w > YLast) ? YLast[COORD_W-1:0] : y_max_i;
`ifdef BOX_SMOOTH_EN
        box_upd.x0 = coord_avg(box_q.x0, box_new.x0);
        box_upd.x1 = coord_avg(box_q.x1, box_new.x1);
        box_upd.y0 = coord_avg(box_q.y0, box_new.y0);
        box_upd.y1 = coord_avg(box_q.y1, box_new.y1);
`else
        box_upd = box_new;
`endif
    end

    // Box and state only move on a frame boundary, so a frame is never torn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q     <= 1'b0;
            state_q     <= StNoBox;
            miss_q      <= '0;
            box_q       <= '0;
            box_valid_q <= 1'b0;
        end else begin
            vsync_q <= vsync_i;
            if (vsync_rise) begin
                case (state_q)
                    StNoBox: begin
                        if (box_ok) begin
                            box_q       <= box_new;
                            state_q     <= StTrack;
                            miss_q      <= '0;
                            box_valid_q <= 1'b1;
                        end
                    end
                    StTrack: begin
                        if (box_ok) begin
                            box_q  <= box_upd;
                            miss_q <= '0;
                        end else begin
                            state_q <= StCoast;
                            miss_q  <= MISS_W'(1);
                        end
                    end
                    StCoast: begin
                        if (box_ok) begin
                            box_q   <= box_upd;
                            state_q <= StTrack;
                            miss_q  <= '0;
                        end else if (miss_q == HoldMax) begin
                            state_q     <= StNoBox;
                            miss_q      <= '0;
                            box_valid_q <= 1'b0;
                        end else begin
                            miss_q <= miss_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q     <= StNoBox;
                        miss_q      <= '0;
                        box_valid_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign vsync_rise_o = vsync_rise;
    assign box_o        = box_q;
    assign box_valid_o  = box_valid_q;

endmodule

// File: rtl/face_box_overlay.sv
// Draws the tracked face box outline onto an RGB565 stream with one clock of latency.
// BOX_SMOOTH_EN (in face_box_tracker) enables averaging of successive boxes.
module face_box_overlay
    import face_pkg::*;
#(
    parameter int unsigned      H_DISP      = 1024,
    parameter int unsigned      V_DISP      = 720,
    parameter logic [RGB_W-1:0] BOX_COLOR   = Rgb565Red,
    parameter int unsigned      LINE_W      = 2,
    parameter int unsigned      MIN_SIZE    = 8,
    parameter int unsigned      HOLD_FRAMES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    face_box_overlay_if.slave        pix_i,
    face_box_overlay_if.master       pix_o,
    input  coord_t                   x_min_i,
    input  coord_t                   x_max_i,
    input  coord_t                   y_min_i,
    input  coord_t                   y_max_i,
    output logic                     box_valid_o
);

    localparam coord_t           XLast = COORD_W'(H_DISP - 1);
    localparam coord_t           YLast = COORD_W'(V_DISP - 1);
    localparam logic [COORD_W:0] LineW = (COORD_W+1)'(LINE_W);

    logic             vsync_rise;
    box_t             box;
    logic             box_valid;

    coord_t           x_cnt_q, y_cnt_q, x_cnt_d, y_cnt_d;
    coord_t           px, py;
    logic [COORD_W:0] px_w, py_w, x0_w, x1_w, y0_w, y1_w;
    logic             in_box, on_edge, hit;

    logic             vsync_q, href_q, clken_q;
    logic [RGB_W-1:0] rgb_q;

    face_box_tracker #(
        .H_DISP      (H_DISP),
        .V_DISP      (V_DISP),
        .MIN_SIZE    (MIN_SIZE),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .vsync_i      (pix_i.vsync),
        .x_min_i      (x_min_i),
        .x_max_i      (x_max_i),
        .y_min_i      (y_min_i),
        .y_max_i      (y_max_i),
        .vsync_rise_o (vsync_rise),
        .box_o        (box),
        .box_valid_o  (box_valid)
    );

    // A pixel arriving with the vsync edge is already the first pixel of the new frame.
    always_comb begin
        px      = vsync_rise ? '0 : x_cnt_q;
        py      = vsync_rise ? '0 : y_cnt_q;
        x_cnt_d = px;
        y_cnt_d = py;
        if (pix_i.clken) begin
            if (px == XLast) begin
                x_cnt_d = '0;
                y_cnt_d = (py == YLast) ? '0 : py + 1'b1;
            end else begin
                x_cnt_d = px + 1'b1;
            end
        end
    end

    // Right/bottom edge test written as x + w > x1 so it cannot underflow.
    always_comb begin
        px_w    = {1'b0, px};
        py_w    = {1'b0, py};
        x0_w    = {1'b0, box.x0};
        x1_w    = {1'b0, box.x1};
        y0_w    = {1'b0, box.y0};
        y1_w    = {1'b0, box.y1};
        in_box  = (px_w >= x0_w) && (px_w <= x1_w) && (py_w >= y0_w) && (py_w <= y1_w);
        on_edge = (px_w < x0_w + LineW) || (px_w + LineW > x1_w) ||
                  (py_w < y0_w + LineW) || (py_w + LineW > y1_w);
        hit     = box_valid && in_box && on_edge;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            clken_q <= 1'b0;
            rgb_q   <= '0;
        end else begin
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
            vsync_q <= pix_i.vsync;
            href_q  <= pix_i.href;
            clken_q <= pix_i.clken;
            rgb_q   <= (pix_i.clken && hit) ? BOX_COLOR : pix_i.rgb;
        end
    end

    assign pix_o.vsync = vsync_q;
    assign pix_o.href  = href_q;
    assign pix_o.clken = clken_q;
    assign pix_o.rgb   = rgb_q;
    assign box_valid_o = box_valid;

endmodule

// File: tb/tb_face_box_overlay.sv
// Self-checking bench for face_box_overlay: frame-level model plus pinned literal checks.
module tb_face_box_overlay;

    localparam int H    = 16;
    localparam int V    = 8;
    localparam int LW   = 1;
    localparam int MS   = 2;
    localparam int HOLD = 2;
    localparam logic [15:0] RED = 16'hF800;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    face_box_overlay_if pin ();
    face_box_overlay_if pout ();

    logic [11:0] bx_min = '0, bx_max = '0, by_min = '0, by_max = '0;
    logic        box_valid;

    face_box_overlay #(
        .H_DISP      (H),
        .V_DISP      (V),
        .BOX_COLOR   (RED),
        .LINE_W      (LW),
        .MIN_SIZE    (MS),
        .HOLD_FRAMES (HOLD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pix_i       (pin),
        .pix_o       (pout),
        .x_min_i     (bx_min),
        .x_max_i     (bx_max),
        .y_min_i     (by_min),
        .y_max_i     (by_max),
        .box_valid_o (box_valid)
    );

    int n_vec = 0;
    int n_err = 0;

    // Model: box seen by the display, miss count, pixel index inside the current frame.
    bit m_valid;
    int m_miss, mx0, mx1, my0, my1, m_idx;
    bit m_vs;

    logic        chk_en = 1'b0;
    logic        e_vs, e_hr, e_ce, e_bv;
    logic [15:0] e_rgb;
    int          e_x, e_y;
    logic [15:0] cap    [V][H];
    logic [15:0] in_pix [V][H];

    function automatic void model_reset();
        m_valid = 0; m_miss = 0; mx0 = 0; mx1 = 0; my0 = 0; my1 = 0; m_idx = 0; m_vs = 0;
    endfunction

    function automatic void model_frame();
        int a0, a1, b0, b1;
        bit ok;
        a0 = int'(bx_min); a1 = int'(bx_max); b0 = int'(by_min); b1 = int'(by_max);
        ok = (a1 >= a0 + MS) && (b1 >= b0 + MS) && (a0 < H) && (b0 < V);
        if (a1 > H - 1) a1 = H - 1;
        if (b1 > V - 1) b1 = V - 1;
        if (ok) begin
`ifdef BOX_SMOOTH_EN
            if (m_valid) begin
                a0 = (mx0 + a0) / 2; a1 = (mx1 + a1) / 2;
                b0 = (my0 + b0) / 2; b1 = (my1 + b1) / 2;
            end
`endif
            mx0 = a0; mx1 = a1; my0 = b0; my1 = b1;
            m_valid = 1; m_miss = 0;
        end else if (m_valid) begin
            if (m_miss == HOLD) begin
                m_valid = 0; m_miss = 0;
            end else begin
                m_miss++;
            end
        end
    endfunction

    function automatic bit on_border(input int x, input int y);
        if (!m_valid) return 0;
        if (x < mx0 || x > mx1 || y < my0 || y > my1) return 0;
        return (x - mx0 < LW) || (mx1 - x < LW) || (y - my0 < LW) || (my1 - y < LW);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Applies one clock of input and records what the outputs must show after the next edge.
    task automatic cyc(input logic vs, input logic hr, input logic ce, input logic [15:0] rgb);
        bit rise;
        int px, py;
        @(negedge clk);
        pin.vsync = vs; pin.href = hr; pin.clken = ce; pin.rgb = rgb;
        rise = vs && !m_vs;
        m_vs = vs;
        if (rise) m_idx = 0;
        px = m_idx % H;
        py = (m_idx / H) % V;
        e_rgb = (ce && on_border(px, py)) ? RED : rgb;
        e_vs = vs; e_hr = hr; e_ce = ce; e_x = px; e_y = py;
        if (ce) begin
            in_pix[py][px] = rgb;
            m_idx++;
        end
        if (rise) model_frame();
        e_bv = m_valid;
        chk_en = 1'b1;
    endtask

    task automatic frame(input int x0, input int x1, input int y0, input int y1,
                         input bit ce_rise, input int npix);
        bx_min = 12'(x0); bx_max = 12'(x1); by_min = 12'(y0); by_max = 12'(y1);
        cyc(1'b1, ce_rise, ce_rise, 16'd5);
        cyc(1'b1, 1'b0, 1'b0, 16'd0);
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        for (int i = (ce_rise ? 1 : 0); i < npix; i++) begin
            cyc(1'b0, 1'b1, 1'b1, 16'(i * 37 + 5));
            if (i % H == H - 1) begin
                cyc(1'b0, 1'b0, 1'b0, 16'd0);
                cyc(1'b0, 1'b0, 1'b0, 16'd0);
            end
        end
        cyc(1'b0, 1'b0, 1'b0, 16'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_vsync"}, {31'd0, pout.vsync}, 32'd0);
        chk({tag, "_href"},  {31'd0, pout.href},  32'd0);
        chk({tag, "_clken"}, {31'd0, pout.clken}, 32'd0);
        chk({tag, "_rgb"},   {16'd0, pout.rgb},   32'd0);
        chk({tag, "_bv"},    {31'd0, box_valid},  32'd0);
    endtask

    task automatic reset_pulse(input string tag);
        @(negedge clk);
        pin.vsync = 1'b0; pin.href = 1'b0; pin.clken = 1'b0; pin.rgb = '0;
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_zero(tag);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cycle-by-cycle compare against the model, one clock after the inputs were applied.
    always @(posedge clk) begin
        #1;
        if (chk_en) begin
            n_vec++;
            if ({pout.vsync, pout.href, pout.clken, pout.rgb, box_valid} !==
                {e_vs, e_hr, e_ce, e_rgb, e_bv}) begin
                n_err++;
                $display("FAIL stream t=%0t px(%0d,%0d): got vs/hr/ce=%b%b%b rgb=%h bv=%b, expected vs/hr/ce=%b%b%b rgb=%h bv=%b",
                         $time, e_x, e_y, pout.vsync, pout.href, pout.clken, pout.rgb, box_valid,
                         e_vs, e_hr, e_ce, e_rgb, e_bv);
            end
            if (e_ce) cap[e_y][e_x] = pout.rgb;
        end
    end

    initial begin
        pin.vsync = 1'b0; pin.href = 1'b0; pin.clken = 1'b0; pin.rgb = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;

        // Basic box (4,10,2,6).
        frame(4, 10, 2, 6, 1'b0, H * V);
        chk("t2_bv",       {31'd0, box_valid}, 32'd1);
        chk("t2_top",      {16'd0, cap[2][7]},  {16'd0, RED});
        chk("t2_bottom",   {16'd0, cap[6][7]},  {16'd0, RED});
        chk("t2_left",     {16'd0, cap[4][4]},  {16'd0, RED});
        chk("t2_right",    {16'd0, cap[4][10]}, {16'd0, RED});
        chk("t2_corner",   {16'd0, cap[6][10]}, {16'd0, RED});
        chk("t2_inside",   {16'd0, cap[4][7]},  {16'd0, in_pix[4][7]});
        chk("t2_above",    {16'd0, cap[1][4]},  {16'd0, in_pix[1][4]});
        chk("t2_right_out",{16'd0, cap[4][11]}, {16'd0, in_pix[4][11]});

        // Reset in the middle of a frame, then one invalid frame.
        frame(4, 10, 2, 6, 1'b0, 40);
        reset_pulse("t1_rst");
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 1'b1, 16'(i * 11 + 3));
        frame(4, 4, 2, 6, 1'b0, H * V);
        chk("t1_bv",   {31'd0, box_valid}, 32'd0);
        chk("t1_pass", {16'd0, cap[2][4]}, {16'd0, in_pix[2][4]});

        // Track, coast through two misses, drop on the third.
        frame(4, 10, 2, 6, 1'b0, H * V);
        frame(4, 4, 2, 6, 1'b0, H * V);
        chk("t3_miss1_bv",  {31'd0, box_valid}, 32'd1);
        chk("t3_miss1_pix", {16'd0, cap[2][4]}, {16'd0, RED});
        frame(4, 4, 2, 6, 1'b0, H * V);
        chk("t3_miss2_bv",  {31'd0, box_valid}, 32'd1);
        chk("t3_miss2_pix", {16'd0, cap[2][4]}, {16'd0, RED});
        frame(4, 4, 2, 6, 1'b0, H * V);
        chk("t3_miss3_bv",  {31'd0, box_valid}, 32'd0);
        chk("t3_miss3_pix", {16'd0, cap[2][4]}, {16'd0, in_pix[2][4]});

        // Undersized box and out-of-range x_min are rejected.
        frame(5, 6, 2, 6, 1'b0, H * V);
        chk("t4_narrow_bv", {31'd0, box_valid}, 32'd0);
        frame(4095, 4095, 2, 6, 1'b0, H * V);
        chk("t4_xmin_bv",   {31'd0, box_valid}, 32'd0);
        chk("t4_xmin_pix",  {16'd0, cap[2][7]}, {16'd0, in_pix[2][7]});

        // Second update: smoothed or direct depending on build.
        frame(4, 10, 2, 6, 1'b0, H * V);
        frame(6, 13, 2, 6, 1'b0, H * V);
        chk("t5_bv",   {31'd0, box_valid}, 32'd1);
        chk("t5_old4", {16'd0, cap[4][4]}, {16'd0, in_pix[4][4]});
`ifdef BOX_SMOOTH_EN
        chk("t5_left",  {16'd0, cap[4][5]},  {16'd0, RED});
        chk("t5_right", {16'd0, cap[4][11]}, {16'd0, RED});
        chk("t5_in",    {16'd0, cap[4][6]},  {16'd0, in_pix[4][6]});
`else
        chk("t5_left",  {16'd0, cap[4][6]},  {16'd0, RED});
        chk("t5_right", {16'd0, cap[4][13]}, {16'd0, RED});
        chk("t5_in",    {16'd0, cap[4][11]}, {16'd0, in_pix[4][11]});
`endif

        // Clamp x_max=20 to 15; stray pixels leave the counter at (5,3) before a clken-on-vsync edge.
        reset_pulse("t6_rst");
        frame(0, 20, 0, 5, 1'b0, H * V + 53);
        frame(0, 20, 0, 5, 1'b1, H * V);
        chk("t6_rise_pix", {16'd0, cap[0][0]},  {16'd0, RED});
        chk("t6_next_pix", {16'd0, cap[0][1]},  {16'd0, RED});
        chk("t6_clamp",    {16'd0, cap[3][15]}, {16'd0, RED});
        chk("t6_inside",   {16'd0, cap[3][14]}, {16'd0, in_pix[3][14]});
        chk("t6_bottom",   {16'd0, cap[5][7]},  {16'd0, RED});
        chk("t6_below",    {16'd0, cap[6][7]},  {16'd0, in_pix[6][7]});

        cyc(1'b0, 1'b0, 1'b0, 16'd0);
        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
